// File: rtl/ps2_scan_decoder_if.sv
// Event bus carrying decoded PS/2 key events from the decoder to its consumer.
// The master side presents the head event and the slave side acknowledges it with evt_ready.
interface ps2_scan_decoder_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_brk;
  logic       evt_ext;

  modport master (
    output evt_valid,
    output evt_code,
    output evt_brk,
    output evt_ext,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_code,
    input  evt_brk,
    input  evt_ext,
    output evt_ready
  );
endinterface

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver with four stages:
// line filter -> 11-bit frame FSM with watchdog -> E0/F0 prefix folding -> show-ahead event FIFO.
// Each event is {ext, brk, code}.
module ps2_scan_decoder #(
  parameter int FIFO_AW    = 3,
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 27000
) (
  input  logic                clock_27mhz,
  input  logic                reset,
  input  logic                ps2c,
  input  logic                ps2d,
  input  logic                err_clr,
  output logic                fifo_overflow,
  output logic                frame_error,
  ps2_scan_decoder_if.master  evt
);

  localparam int FCW   = $clog2(FILTER_LEN + 1);
  localparam int WDW   = $clog2(TIMEOUT + 1);
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]     raw_lines;
  logic [1:0]     sync1;
  logic [1:0]     sync2;
  logic [1:0]     filt;
  logic [FCW-1:0] fcnt [2];
  logic           ps2c_f;
  logic           ps2d_f;
  logic           ps2c_f_d;
  logic           sample;

  state_t         state;
  logic [2:0]     bitcnt;
  logic [7:0]     shreg;
  logic           parity_bit;
  logic [WDW-1:0] wdog;
  logic           byte_stb;
  logic [7:0]     data_byte;

  logic           ext_p;
  logic           brk_p;
  logic           push_req;

  logic [9:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               full;
  logic               pop;
  logic               wr_en;
  logic [9:0]         head;

  assign raw_lines = {ps2d, ps2c};
  assign ps2c_f    = filt[0];
  assign ps2d_f    = filt[1];
  assign sample    = ps2c_f_d & ~ps2c_f;

  // Synchronise both lines, then only follow a line once it has held a new level for FILTER_LEN clocks.
  always_ff @(posedge clock_27mhz or posedge reset) begin
    if (reset) begin
      sync1    <= 2'b11;
      sync2    <= 2'b11;
      filt     <= 2'b11;
      ps2c_f_d <= 1'b1;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      sync1    <= raw_lines;
      sync2    <= sync1;
      ps2c_f_d <= filt[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FCW'(FILTER_LEN - 1)) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  // Frame FSM plus watchdog; a stalled partial frame is abandoned and reported as a frame error.
  always_ff @(posedge clock_27mhz or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bitcnt      <= '0;
      shreg       <= '0;
      parity_bit  <= 1'b0;
      wdog        <= '0;
      byte_stb    <= 1'b0;
      data_byte   <= '0;
      frame_error <= 1'b0;
    end else begin
      byte_stb    <= 1'b0;
      frame_error <= 1'b0;
      if (state == IDLE || sample) begin
        wdog <= '0;
      end else if (wdog == WDW'(TIMEOUT - 1)) begin
        wdog        <= '0;
        state       <= IDLE;
        frame_error <= 1'b1;
      end else begin
        wdog <= wdog + 1'b1;
      end
      if (sample) begin
        case (state)
          IDLE: begin
            if (!ps2d_f) begin
              state  <= DATA;
              bitcnt <= '0;
            end else begin
              frame_error <= 1'b1;
            end
          end
          DATA: begin
            shreg  <= {ps2d_f, shreg[7:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity_bit <= ps2d_f;
            state      <= STOP;
          end
          STOP: begin
            if (ps2d_f && (^{shreg, parity_bit})) begin
              byte_stb  <= 1'b1;
              data_byte <= shreg;
            end else begin
              frame_error <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign push_req = byte_stb && (data_byte != 8'hE0) && (data_byte != 8'hF0);

  // Fold E0/F0 prefixes into flags that tag the next real scan code; any frame error forgets them.
  always_ff @(posedge clock_27mhz or posedge reset) begin
    if (reset) begin
      ext_p <= 1'b0;
      brk_p <= 1'b0;
    end else if (frame_error) begin
      ext_p <= 1'b0;
      brk_p <= 1'b0;
    end else if (byte_stb) begin
      if (data_byte == 8'hE0) begin
        ext_p <= 1'b1;
      end else if (data_byte == 8'hF0) begin
        brk_p <= 1'b1;
      end else begin
        ext_p <= 1'b0;
        brk_p <= 1'b0;
      end
    end
  end

  assign full  = (count == DEPTH[FIFO_AW:0]);
  assign pop   = evt.evt_valid & evt.evt_ready;
  assign wr_en = push_req & (~full | pop);
  assign head  = mem[rd_ptr];

  // Event storage; contents need no reset because the occupancy count gates visibility.
  always_ff @(posedge clock_27mhz) begin
    if (wr_en) mem[wr_ptr] <= {ext_p, brk_p, data_byte};
  end

  // FIFO pointers, occupancy and the sticky overflow flag (a new overflow beats err_clr).
  always_ff @(posedge clock_27mhz or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      fifo_overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && full && !pop) begin
        fifo_overflow <= 1'b1;
      end else if (err_clr) begin
        fifo_overflow <= 1'b0;
      end
    end
  end

  assign evt.evt_valid = (count != '0);
  assign evt.evt_code  = evt.evt_valid ? head[7:0] : 8'h00;
  assign evt.evt_brk   = evt.evt_valid & head[8];
  assign evt.evt_ext   = evt.evt_valid & head[9];

endmodule
